// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational alu between two requesters:
//   port 0 : execute stage
//   port 1 : address / branch-target helper
//
// Requests are granted round-robin in the same cycle (reqN_ready = grantN).
// An accepted operation goes into the issue register. The issue register
// drives the alu in the following cycle. The alu result is captured in the
// result register, and a one-cycle rspN_valid pulse is raised two cycles
// after acceptance.
//
// Ports
//   clock, reset                     system clock, synchronous active-high reset
//   reqN_valid / reqN_ready          request handshake, N = 0, 1
//   reqN_function, reqN_a, reqN_b    request payload
//   alu_function, alu_operand_a/b    drive to the shared alu (0 when idle)
//   alu_result                       combinational result from the alu
//   rsp0_valid, rsp1_valid           one-cycle response pulses
//   rsp_result                       registered result, held until next response
//
// Optional build macro RVSIMPLE_ALU_ARB_PERF_EN adds three saturating
// counters (all WIDTH bits wide):
//   perf_grant0, perf_grant1         transfers per port
//   perf_conflict                    cycles with both valids high
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH       = 32,
  parameter int FUNCT_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [FUNCT_WIDTH-1:0] req0_function,
  input  logic [WIDTH-1:0]       req0_a,
  input  logic [WIDTH-1:0]       req0_b,

  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [FUNCT_WIDTH-1:0] req1_function,
  input  logic [WIDTH-1:0]       req1_a,
  input  logic [WIDTH-1:0]       req1_b,

  output logic [FUNCT_WIDTH-1:0] alu_function,
  output logic [WIDTH-1:0]       alu_operand_a,
  output logic [WIDTH-1:0]       alu_operand_b,
  input  logic [WIDTH-1:0]       alu_result,

  output logic                   rsp0_valid,
  output logic                   rsp1_valid,
  output logic [WIDTH-1:0]       rsp_result
`ifdef RVSIMPLE_ALU_ARB_PERF_EN
  ,
  output logic [WIDTH-1:0]       perf_grant0,
  output logic [WIDTH-1:0]       perf_grant1,
  output logic [WIDTH-1:0]       perf_conflict
`endif
);

  logic                   grant0;
  logic                   grant1;
  logic                   last_grant;  // port granted most recently

  logic                   iss_valid;
  logic                   iss_id;
  logic [FUNCT_WIDTH-1:0] iss_funct;
  logic [WIDTH-1:0]       iss_a;
  logic [WIDTH-1:0]       iss_b;

  // ---------------------------------------------------------------------------
  // Grant selection. A grant implies the matching valid, so a grant is also a
  // transfer. When both ports are valid, the port not granted last time wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      case ({req1_valid, req0_valid})
        2'b01:   grant0 = 1'b1;
        2'b10:   grant1 = 1'b1;
        2'b11: begin
          if (last_grant) grant0 = 1'b1;
          else            grant1 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ---------------------------------------------------------------------------
  // Control registers: last_grant, issue valid/id, and response stage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only. Each register
    // then takes the value from before the edge, whatever the statement order.
    if (reset) begin
      last_grant <= 1'b1;       // port 0 wins the first conflict
      iss_valid  <= 1'b0;       // in-flight operations are dropped
      iss_id     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
    end else begin
      if (grant0 || grant1) last_grant <= grant1;
      iss_valid  <= grant0 || grant1;
      if (grant0 || grant1) iss_id <= grant1;
      rsp0_valid <= iss_valid && !iss_id;
      rsp1_valid <= iss_valid &&  iss_id;
      if (iss_valid) rsp_result <= alu_result;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue payload. NOTE: these datapath registers are deliberately not reset.
  // Their contents are only visible through the iss_valid gate below, so a
  // reset here would add fanout and change nothing observable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (grant0 || grant1) begin
      iss_funct <= grant1 ? req1_function : req0_function;
      iss_a     <= grant1 ? req1_a        : req0_a;
      iss_b     <= grant1 ? req1_b        : req0_b;
    end
  end

  // Idle alu inputs are forced to zero. This keeps them deterministic and
  // keeps the alu from toggling.
  assign alu_function  = iss_valid ? iss_funct : '0;
  assign alu_operand_a = iss_valid ? iss_a     : '0;
  assign alu_operand_b = iss_valid ? iss_b     : '0;

`ifdef RVSIMPLE_ALU_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters.
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (grant0) perf_grant0 <= sat_inc(perf_grant0);
      if (grant1) perf_grant1 <= sat_inc(perf_grant1);
      if (req0_valid && req1_valid) perf_conflict <= sat_inc(perf_conflict);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed testbench for alu_arbiter. A small alu model in this bench
// supplies alu_result. Inputs change on the falling edge. Outputs are sampled
// 1 time unit later, well away from the rising edge that updates the design.
// Build with +define+RVSIMPLE_ALU_ARB_PERF_EN to exercise the counters.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int FW = 5;

  localparam logic [FW-1:0] ALU_ADD = 5'd1;
  localparam logic [FW-1:0] ALU_SUB = 5'd2;
  localparam logic [FW-1:0] ALU_XOR = 5'd6;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready;
  logic [FW-1:0] req0_function;
  logic [W-1:0]  req0_a, req0_b;
  logic          req1_valid, req1_ready;
  logic [FW-1:0] req1_function;
  logic [W-1:0]  req1_a, req1_b;
  logic [FW-1:0] alu_function;
  logic [W-1:0]  alu_operand_a, alu_operand_b, alu_result;
  logic          rsp0_valid, rsp1_valid;
  logic [W-1:0]  rsp_result;
`ifdef RVSIMPLE_ALU_ARB_PERF_EN
  logic [W-1:0]  perf_grant0, perf_grant1, perf_conflict;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  alu_arbiter #(.WIDTH(W), .FUNCT_WIDTH(FW)) dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_function (req0_function),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_function (req1_function),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .alu_function  (alu_function),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_result    (alu_result),
    .rsp0_valid    (rsp0_valid),
    .rsp1_valid    (rsp1_valid),
    .rsp_result    (rsp_result)
`ifdef RVSIMPLE_ALU_ARB_PERF_EN
    ,
    .perf_grant0   (perf_grant0),
    .perf_grant1   (perf_grant1),
    .perf_conflict (perf_conflict)
`endif
  );

  always #5 clock = ~clock;

  // Reference alu for the codes this bench uses.
  always_comb begin
    alu_result = '0;
    case (alu_function)
      ALU_ADD: alu_result = alu_operand_a + alu_operand_b;
      ALU_SUB: alu_result = alu_operand_a - alu_operand_b;
      ALU_XOR: alu_result = alu_operand_a ^ alu_operand_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge. This is the start of a new "cycle"
  // from the bench's point of view.
  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic drive0(input logic v, input logic [FW-1:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    req0_valid = v; req0_function = f; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [FW-1:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    req1_valid = v; req1_function = f; req1_a = a; req1_b = b;
  endtask

  task automatic check_alu(input string tag, input logic [FW-1:0] f,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    check({tag, "_alu_f"}, W'(alu_function), W'(f));
    check({tag, "_alu_a"}, alu_operand_a, a);
    check({tag, "_alu_b"}, alu_operand_b, b);
  endtask

  task automatic check_rsp(input string tag, input logic v0, input logic v1);
    check({tag, "_rsp0"}, W'(rsp0_valid), W'(v0));
    check({tag, "_rsp1"}, W'(rsp1_valid), W'(v1));
  endtask

  task automatic check_ready(input string tag, input logic r0, input logic r1);
    check({tag, "_rdy0"}, W'(req0_ready), W'(r0));
    check({tag, "_rdy1"}, W'(req1_ready), W'(r1));
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive0(1'b1, ALU_ADD, 32'd1, 32'd1);
    drive1(1'b1, ALU_XOR, 32'd2, 32'd2);

    // ---- Reset state: outputs zero and ready forced low despite valids ----
    next_cycle();
    next_cycle();
    #1;
    check_ready("rst", 1'b0, 1'b0);
    check_rsp("rst", 1'b0, 1'b0);
    check("rst_result", rsp_result, '0);
    check_alu("rst", '0, '0, '0);
`ifdef RVSIMPLE_ALU_ARB_PERF_EN
    check("rst_perf_g0", perf_grant0, '0);
    check("rst_perf_g1", perf_grant1, '0);
    check("rst_perf_cf", perf_conflict, '0);
`endif

    // ---- Test 1: req0 alone, ADD 5,7 -> 12 after two cycles ----
    drive1(1'b0, '0, '0, '0);
    drive0(1'b1, ALU_ADD, 32'd5, 32'd7);
    reset = 1'b0;
    #1;
    check_ready("t1_c1", 1'b1, 1'b0);
    next_cycle();
    drive0(1'b0, '0, '0, '0);
    #1;
    check_alu("t1_c2", ALU_ADD, 32'd5, 32'd7);
    check_rsp("t1_c2", 1'b0, 1'b0);
    next_cycle();
    #1;
    check_rsp("t1_c3", 1'b1, 1'b0);
    check("t1_c3_result", rsp_result, 32'd12);
    check_alu("t1_c3", '0, '0, '0);

    // ---- Test 2: both valid for 4 cycles after reset -> 0,1,0,1 ----
    next_cycle();
    do_reset(2);
    drive0(1'b1, ALU_SUB, 32'd10, 32'd3);
    drive1(1'b1, ALU_XOR, 32'hF0, 32'h0F);
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin
        drive0(1'b0, '0, '0, '0);
        drive1(1'b0, '0, '0, '0);
      end
      #1;
      check_ready($sformatf("t2_c%0d", c), c < 4 && c % 2 == 0,
                  c < 4 && c % 2 == 1);
      check_rsp($sformatf("t2_c%0d", c), c >= 2 && c % 2 == 0,
                c >= 2 && c % 2 == 1);
      if (c >= 2)
        check($sformatf("t2_c%0d_result", c), rsp_result,
              (c % 2 == 0) ? 32'd7 : 32'hFF);
      next_cycle();
    end

    // ---- Test 3: req1 alone for 3 cycles, then conflict goes to port 0 ----
    drive1(1'b1, ALU_XOR, 32'hF0, 32'h0F);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_ready($sformatf("t3_solo%0d", c), 1'b0, 1'b1);
      next_cycle();
    end
    drive0(1'b1, ALU_SUB, 32'd10, 32'd3);
    #1;
    check_ready("t3_conflict", 1'b1, 1'b0);

    // ---- Test 4: reset in the cycle after a transfer drops the operation ----
    next_cycle();
    reset = 1'b1;
    #1;
    check_ready("t4_inrst", 1'b0, 1'b0);
    next_cycle();
    reset = 1'b0;
    drive0(1'b1, ALU_ADD, 32'd100, 32'd23);
    #1;
    check_rsp("t4_post", 1'b0, 1'b0);
    check("t4_post_result", rsp_result, '0);
    check_alu("t4_post", '0, '0, '0);
    check_ready("t4_post", 1'b1, 1'b0);
    next_cycle();
    drive0(1'b0, '0, '0, '0);
    drive1(1'b0, '0, '0, '0);
    #1;
    check_alu("t4_iss", ALU_ADD, 32'd100, 32'd23);
    next_cycle();
    #1;
    check_rsp("t4_rsp", 1'b1, 1'b0);
    check("t4_rsp_result", rsp_result, 32'd123);

    // ---- Test 5: idle for 5 cycles -> alu drive 0, result held ----
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      #1;
      check_alu($sformatf("t5_idle%0d", c), '0, '0, '0);
      check_rsp($sformatf("t5_idle%0d", c), 1'b0, 1'b0);
      check($sformatf("t5_idle%0d_result", c), rsp_result, 32'd123);
    end

`ifdef RVSIMPLE_ALU_ARB_PERF_EN
    // ---- Perf: 3 conflicts (0,1,0) then 2 solo req0 transfers ----
    next_cycle();
    do_reset(2);
    #1;
    check("perf_clr_g0", perf_grant0, '0);
    check("perf_clr_cf", perf_conflict, '0);
    drive0(1'b1, ALU_ADD, 32'd1, 32'd2);
    drive1(1'b1, ALU_XOR, 32'd3, 32'd4);
    for (int c = 0; c < 3; c++) next_cycle();
    drive1(1'b0, '0, '0, '0);
    for (int c = 0; c < 2; c++) next_cycle();
    drive0(1'b0, '0, '0, '0);
    #1;
    check("perf_g0", perf_grant0, 32'd4);
    check("perf_g1", perf_grant1, 32'd1);
    check("perf_cf", perf_conflict, 32'd3);
`endif

    next_cycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
